// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, the MEM-stage core port, the external
// loader/debug port and the data memory; slave = arbiter side, master = environment side.
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  core_rd;
   logic                  core_wr;
   logic [DM_ADDRESS-1:0] core_addr;
   logic [DATA_W-1:0]     core_wdata;
   logic [2:0]            core_funct3;
   logic [DATA_W-1:0]     core_rdata;
   logic                  core_stall;

   logic                  ext_req;
   logic                  ext_we;
   logic [DM_ADDRESS-1:0] ext_addr;
   logic [DATA_W-1:0]     ext_wdata;
   logic                  ext_gnt;
   logic                  ext_rvalid;
   logic [DATA_W-1:0]     ext_rdata;

   logic                  mem_rd;
   logic                  mem_wr;
   logic [DM_ADDRESS-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [2:0]            mem_funct3;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  core_rd, core_wr, core_addr, core_wdata, core_funct3,
      output core_rdata, core_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
      input  mem_rdata
   );

   modport master (
      output core_rd, core_wr, core_addr, core_wdata, core_funct3,
      input  core_rdata, core_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MEM stage and an external port.
// Define DMEM_ARB_FAIRNESS_EN to bound core grants while ext_req waits; otherwise core has strict priority.
module dmem_arbiter #(
   parameter int DM_ADDRESS      = 9,
   parameter int DATA_W          = 32,
   parameter int MAX_CORE_STREAK = 4
) (
   input  logic            clk,
   input  logic            reset,
   dmem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, CORE, EXT} owner_e;

   owner_e            state;
   owner_e            owner;
   logic              core_req;
   logic              force_ext;
   logic              ext_rd_q;
   logic [DATA_W-1:0] ext_rdata_q;

   if (MAX_CORE_STREAK < 1 || MAX_CORE_STREAK > 15) begin : g_bad_streak
      $error("MAX_CORE_STREAK must be in 1..15");
   end

   assign core_req = bus.core_rd | bus.core_wr;

`ifdef DMEM_ARB_FAIRNESS_EN
   localparam logic [3:0] STREAK_MAX = 4'(MAX_CORE_STREAK);
   logic [3:0] streak_cnt;

   assign force_ext = bus.ext_req && (streak_cnt == STREAK_MAX);

   // Counts core grants that overtook a waiting external request.
   always_ff @(posedge clk) begin
      if (reset)
         streak_cnt <= '0;
      else if (owner == EXT || !bus.ext_req)
         streak_cnt <= '0;
      else if (owner == CORE && streak_cnt != STREAK_MAX)
         streak_cnt <= streak_cnt + 4'd1;
   end
`else
   assign force_ext = 1'b0;
`endif

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      owner = IDLE;
      if (!reset) begin
         if (core_req && !force_ext) owner = CORE;
         else if (bus.ext_req)       owner = EXT;
      end
   end

   always_comb begin
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      bus.mem_funct3 = 3'b000;
      bus.core_rdata = '0;
      bus.core_stall = 1'b0;
      bus.ext_gnt    = 1'b0;
      unique case (owner)
         CORE: begin
            bus.mem_rd     = bus.core_rd & ~bus.core_wr;
            bus.mem_wr     = bus.core_wr;
            bus.mem_addr   = bus.core_addr;
            bus.mem_wdata  = bus.core_wdata;
            bus.mem_funct3 = bus.core_funct3;
            bus.core_rdata = bus.mem_rdata;
         end
         EXT: begin
            bus.mem_rd     = ~bus.ext_we;
            bus.mem_wr     = bus.ext_we;
            bus.mem_addr   = bus.ext_addr;
            bus.mem_wdata  = bus.ext_wdata;
            bus.mem_funct3 = 3'b010;
            bus.ext_gnt    = 1'b1;
            bus.core_stall = core_req;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ext_rd_q    <= 1'b0;
         ext_rdata_q <= '0;
      end else begin
         state    <= owner;
         ext_rd_q <= (owner == EXT) && !bus.ext_we;
         if (owner == EXT && !bus.ext_we)
            ext_rdata_q <= bus.mem_rdata;
      end
   end

   // A response due in a reset cycle is dropped rather than presented.
   assign bus.ext_rvalid = (state == EXT) && ext_rd_q && !reset;
   assign bus.ext_rdata  = reset ? '0 : ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, multi-cycle corner sequences
// and randomized traffic compared against a rule-level reference model.
module tb_dmem_arbiter;

   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int MAX = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   typedef struct packed {
      logic          rst;
      logic          crd;
      logic          cwr;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwdata;
      logic [2:0]    cf3;
      logic          ereq;
      logic          ewe;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewdata;
      logic [DW-1:0] mrdata;
   } in_t;

   typedef struct {
      in_t           i;
      logic          x_rd;
      logic          x_wr;
      logic [AW-1:0] x_addr;
      logic          x_gnt;
      logic          x_stall;
   } vec_t;

   logic clk;
   logic reset;
   dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_CORE_STREAK(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int            n_vec = 0;
   int            n_bad = 0;
   int            m_streak = 0;
   bit            m_rv = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   in_t           cur;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic in_t mk(input logic rst, input logic crd, input logic cwr, input logic [AW-1:0] caddr,
                              input logic ereq, input logic ewe, input logic [AW-1:0] eaddr);
      in_t r;
      r.rst    = rst;
      r.crd    = crd;
      r.cwr    = cwr;
      r.caddr  = caddr;
      r.cwdata = $urandom;
      r.cf3    = 3'($urandom_range(0, 7));
      r.ereq   = ereq;
      r.ewe    = ewe;
      r.eaddr  = eaddr;
      r.ewdata = $urandom;
      r.mrdata = $urandom;
      return r;
   endfunction

   // 0 = nobody, 1 = core, 2 = external
   function automatic int exp_owner(input in_t i);
      bit force_ext;
      force_ext = FAIR && i.ereq && (m_streak >= MAX);
      if (i.rst)                          return 0;
      if ((i.crd || i.cwr) && !force_ext) return 1;
      if (i.ereq)                         return 2;
      return 0;
   endfunction

   task automatic apply(input in_t i);
      int            own;
      logic          x_rd, x_wr;
      logic [AW-1:0] x_addr;
      logic [DW-1:0] x_wd;
      logic [2:0]    x_f3;
      cur             = i;
      reset           = i.rst;
      bus.core_rd     = i.crd;
      bus.core_wr     = i.cwr;
      bus.core_addr   = i.caddr;
      bus.core_wdata  = i.cwdata;
      bus.core_funct3 = i.cf3;
      bus.ext_req     = i.ereq;
      bus.ext_we      = i.ewe;
      bus.ext_addr    = i.eaddr;
      bus.ext_wdata   = i.ewdata;
      bus.mem_rdata   = i.mrdata;
      #3;
      own    = exp_owner(i);
      x_rd   = 1'b0;
      x_wr   = 1'b0;
      x_addr = '0;
      x_wd   = '0;
      x_f3   = 3'b000;
      if (own == 1) begin
         x_rd = i.crd && !i.cwr; x_wr = i.cwr; x_addr = i.caddr; x_wd = i.cwdata; x_f3 = i.cf3;
         check("core_rdata", bus.core_rdata, i.mrdata);
      end else if (own == 2) begin
         x_rd = !i.ewe; x_wr = i.ewe; x_addr = i.eaddr; x_wd = i.ewdata; x_f3 = 3'b010;
      end
      check("mem_rd", 32'(bus.mem_rd), 32'(x_rd));
      check("mem_wr", 32'(bus.mem_wr), 32'(x_wr));
      check("mem_addr", 32'(bus.mem_addr), 32'(x_addr));
      check("mem_wdata", bus.mem_wdata, x_wd);
      check("mem_funct3", 32'(bus.mem_funct3), 32'(x_f3));
      check("ext_gnt", 32'(bus.ext_gnt), 32'(own == 2));
      check("core_stall", 32'(bus.core_stall), 32'(own == 2 && (i.crd || i.cwr)));
      check("ext_rvalid", 32'(bus.ext_rvalid), 32'(m_rv && !i.rst));
      check("ext_rdata", bus.ext_rdata, i.rst ? '0 : m_rdata);
   endtask

   task automatic tick();
      int own;
      own = exp_owner(cur);
      @(posedge clk);
      if (cur.rst) begin
         m_streak = 0;
         m_rv     = 1'b0;
         m_rdata  = '0;
      end else begin
         m_rv = (own == 2) && !cur.ewe;
         if (m_rv) m_rdata = cur.mrdata;
         if (own == 2 || !cur.ereq) m_streak = 0;
         else if (own == 1)         m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
      end
      #1;
   endtask

   vec_t tbl[10];
   in_t  v;
   logic [DW-1:0] rd_word;
   bit   pend;

   initial begin
      tbl[0] = '{mk(0, 0, 0, 9'h000, 0, 0, 9'h000), 0, 0, 9'h000, 0, 0};
      tbl[1] = '{mk(0, 1, 0, 9'h020, 0, 0, 9'h000), 1, 0, 9'h020, 0, 0};
      tbl[2] = '{mk(0, 0, 1, 9'h044, 0, 0, 9'h000), 0, 1, 9'h044, 0, 0};
      tbl[3] = '{mk(0, 0, 0, 9'h000, 1, 0, 9'h010), 1, 0, 9'h010, 1, 0};
      tbl[4] = '{mk(0, 0, 0, 9'h000, 1, 1, 9'h0A0), 0, 1, 9'h0A0, 1, 0};
      tbl[5] = '{mk(0, 0, 1, 9'h008, 1, 0, 9'h1F0), 0, 1, 9'h008, 0, 0};
      tbl[6] = '{mk(0, 1, 1, 9'h004, 0, 0, 9'h000), 0, 1, 9'h004, 0, 0};
      tbl[7] = '{mk(0, 1, 0, 9'h1FF, 1, 1, 9'h003), 1, 0, 9'h1FF, 0, 0};
      tbl[8] = '{mk(0, 0, 0, 9'h000, 1, 0, 9'h100), 1, 0, 9'h100, 1, 0};
      tbl[9] = '{mk(0, 0, 0, 9'h000, 0, 0, 9'h000), 0, 0, 9'h000, 0, 0};

      // Reset with an external request pending: no grant, no enables.
      for (int k = 0; k < 2; k++) begin
         apply(mk(1, 1, 0, 9'h055, 1, 0, 9'h011));
         check("rst_gnt", 32'(bus.ext_gnt), 32'd0);
         check("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
         tick();
      end

      for (int k = 0; k < 10; k++) begin
         apply(tbl[k].i);
         check($sformatf("tbl%0d_rd", k), 32'(bus.mem_rd), 32'(tbl[k].x_rd));
         check($sformatf("tbl%0d_wr", k), 32'(bus.mem_wr), 32'(tbl[k].x_wr));
         check($sformatf("tbl%0d_addr", k), 32'(bus.mem_addr), 32'(tbl[k].x_addr));
         check($sformatf("tbl%0d_gnt", k), 32'(bus.ext_gnt), 32'(tbl[k].x_gnt));
         check($sformatf("tbl%0d_stall", k), 32'(bus.core_stall), 32'(tbl[k].x_stall));
         if (k == 4) check("ext_rd_resp", bus.ext_rdata, tbl[3].i.mrdata);
         if (k == 4) check("ext_rd_rvalid", 32'(bus.ext_rvalid), 32'd1);
         tick();
      end

      // Core requests every cycle while ext_req is held.
      v = mk(0, 0, 1, 9'h030, 1, 0, 9'h040);
      for (int k = 0; k < (FAIR ? 6 : 20); k++) begin
         apply(v);
         check($sformatf("streak%0d_gnt", k), 32'(bus.ext_gnt), 32'(FAIR && k == 4));
         check($sformatf("streak%0d_stall", k), 32'(bus.core_stall), 32'(FAIR && k == 4));
         tick();
      end
      apply(mk(0, 0, 0, 9'h000, 0, 0, 9'h000));
      tick();

      // Reset arriving in the cycle the read response is due.
      v = mk(0, 0, 0, 9'h000, 1, 0, 9'h0C4);
      rd_word = v.mrdata;
      apply(v);
      check("mid_gnt", 32'(bus.ext_gnt), 32'd1);
      tick();
      apply(mk(1, 0, 0, 9'h000, 1, 0, 9'h0C8));
      check("mid_rvalid", 32'(bus.ext_rvalid), 32'd0);
      check("mid_rdata", bus.ext_rdata, 32'd0);
      check("mid_gnt_rst", 32'(bus.ext_gnt), 32'd0);
      tick();
      apply(mk(0, 0, 0, 9'h000, 0, 0, 9'h000));
      check("post_rvalid", 32'(bus.ext_rvalid), 32'd0);
      check("post_rdata", bus.ext_rdata, 32'd0);
      check("post_not_stale", 32'(bus.ext_rdata == rd_word && rd_word != 0), 32'd0);
      tick();

      // Back-to-back external reads with the core idle.
      for (int k = 0; k < 3; k++) begin
         v = mk(0, 0, 0, 9'h000, 1, 0, AW'(9'h010 + k));
         apply(v);
         check($sformatf("b2b%0d_gnt", k), 32'(bus.ext_gnt), 32'd1);
         if (k > 0) check($sformatf("b2b%0d_rvalid", k), 32'(bus.ext_rvalid), 32'd1);
         tick();
      end

      // Random traffic; a waiting external request is held until granted.
      pend = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         in_t r;
         r = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 4),
                AW'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), AW'($urandom));
         if (pend) begin
            r.ereq   = 1'b1;
            r.ewe    = cur.ewe;
            r.eaddr  = cur.eaddr;
            r.ewdata = cur.ewdata;
         end
         apply(r);
         pend = r.ereq && (exp_owner(r) != 2) && !r.rst;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
